lfsr_prng: RTL and testbench
============================

LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 SHALL have parameter DW, default 16, meaning state/output width; legal range 3..32.
REQ-002 SHALL have parameter POLY, default 16'hD008, meaning the DW-bit tap mask.
REQ-003 SHALL have parameter MODE, default 0, meaning 0 = Fibonacci and 1 = Galois.
REQ-004 SHALL have parameter SEED_DEF, default 1, meaning the reset seed; a value of 0 SHALL be treated as 1.
REQ-005 SHALL have port i_clk_prng, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port i_rst_prng, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_en_prng, input, 1 bit: step request.
REQ-008 SHALL have port i_load_prng, input, 1 bit: seed load strobe.
REQ-009 SHALL have port i_seed_prng, input, DW bits: seed value.
REQ-010 SHALL have port i_rdy_prng, input, 1 bit: consumer ready.
REQ-011 SHALL have port o_rnd_prng, output, DW bits: registered random word.
REQ-012 SHALL have port o_vld_prng, output, 1 bit: o_rnd_prng holds an unconsumed word.
REQ-013 SHALL have port o_wrap_prng, output, 1 bit: one-cycle pulse when the sequence returns to its start seed.
REQ-014 SHALL have port o_cnt_prng, output, DW bits: steps taken since the last load, reset or wrap.
REQ-015 SHALL have port o_zerr_prng, output, 1 bit: sticky flag set when a zero seed is rejected.

Function
REQ-016 Fibonacci next state SHALL be {s[DW-2:0], ^(s & POLY)}.
REQ-017 Galois next state SHALL be (s >> 1) ^ (s[0] ? POLY : 0).
REQ-018 Step condition SHALL be i_en_prng & !i_load_prng & (!o_vld_prng | i_rdy_prng).
REQ-019 On a step, the block SHALL:
- set the state and o_rnd_prng to next(state);
- set o_vld_prng to 1;
- increment o_cnt_prng modulo 2^DW.
REQ-020 On a step where next(state) equals the stored start seed, the block SHALL pulse o_wrap_prng high for exactly one cycle and clear o_cnt_prng to 0 instead of incrementing it.
REQ-021 When o_vld_prng=1, i_rdy_prng=1 and no step occurs, o_vld_prng SHALL clear to 0 on the next edge; o_rnd_prng SHALL hold its value.
REQ-022 When o_vld_prng=1 and i_rdy_prng=0, o_rnd_prng, o_vld_prng, the state and o_cnt_prng SHALL hold regardless of i_en_prng (backpressure; no word lost).
REQ-023 i_load_prng SHALL take priority over a step.
REQ-024 A load with a nonzero seed SHALL set the state and the start seed to i_seed_prng, o_cnt_prng to 0, o_vld_prng to 0 and o_zerr_prng to 0.
REQ-025 A load with a zero seed SHALL set the state and the start seed to SEED_DEF, o_cnt_prng to 0, o_vld_prng to 0 and o_zerr_prng to 1.
REQ-026 o_zerr_prng SHALL remain 1 until a nonzero load or reset.
REQ-027 Latency from a step request to a valid word SHALL be one clock.
REQ-028 The state SHALL never become all-zero.

Reset
REQ-029 Asserting i_rst_prng SHALL immediately set the state and start seed to SEED_DEF, o_rnd_prng to 0, o_vld_prng to 0, o_wrap_prng to 0, o_cnt_prng to 0 and o_zerr_prng to 0.
REQ-030 Reset asserted mid-sequence or during backpressure SHALL discard the pending word.
REQ-031 No step SHALL occur in the cycle reset deasserts unless i_en_prng is sampled high at a subsequent edge.

Verification
REQ-032 Defaults, reset, then i_en_prng=1 and i_rdy_prng=1 held -> o_rnd_prng = 0x0002, 0x0004, 0x0008, 0x0011 on successive cycles; o_vld_prng high from the first edge.
REQ-033 DW=4, POLY=4'hC, MODE=0, seed 1, i_en_prng=1 and i_rdy_prng=1 held -> 15 distinct nonzero words, o_wrap_prng pulses on step 15 with o_rnd_prng=0x1, then o_cnt_prng=0.
REQ-034 Defaults, MODE=1, POLY=16'hB400, seed 1, one step -> o_rnd_prng = 0xB400; second step -> 0x5A00.
REQ-035 A step with i_rdy_prng=0 for 5 cycles while i_en_prng=1 -> o_rnd_prng and o_cnt_prng frozen; on i_rdy_prng=1 the next word follows with no skip.
REQ-036 i_load_prng=1 with i_seed_prng=0 asserted together with i_en_prng -> state=SEED_DEF, o_zerr_prng=1, no step; a later load of 0x00A5 -> o_zerr_prng=0 and the next word is next(0x00A5).
REQ-037 Asynchronous reset mid-clock during an active sequence -> outputs go to reset values before the next edge.

Source files
------------

// File: rtl/lfsr_prng.sv
// Parameterised Fibonacci/Galois LFSR random-word source with a valid/ready
// output register, wrap detection against the loaded start seed, and seed guarding.
module lfsr_prng #(
  parameter int unsigned DW       = 16,
  parameter logic [31:0] POLY     = 32'h0000_D008,
  parameter int unsigned MODE     = 0,
  parameter logic [31:0] SEED_DEF = 32'd1
) (
  input  logic          i_clk_prng,
  input  logic          i_rst_prng,
  input  logic          i_en_prng,
  input  logic          i_load_prng,
  input  logic [DW-1:0] i_seed_prng,
  input  logic          i_rdy_prng,
  output logic [DW-1:0] o_rnd_prng,
  output logic          o_vld_prng,
  output logic          o_wrap_prng,
  output logic [DW-1:0] o_cnt_prng,
  output logic          o_zerr_prng
);

  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] TAPS     = POLY[DW-1:0];
  localparam logic [DW-1:0] SEED_RAW = SEED_DEF[DW-1:0];
  localparam logic [DW-1:0] SEED_RST = (SEED_RAW == '0) ? ONE : SEED_RAW;

  logic [DW-1:0] state;
  logic [DW-1:0] start_seed;
  logic [DW-1:0] nxt_raw;
  logic [DW-1:0] nxt;
  logic          step;
  logic          seed_ok;

  always_comb begin
    nxt_raw = '0;
    if (MODE == 0) begin
      nxt_raw = {state[DW-2:0], ^(state & TAPS)};
    end else begin
      nxt_raw = (state >> 1) ^ (state[0] ? TAPS : '0);
    end
    // A degenerate tap mask could map a state to zero; fall back to the reset seed.
    nxt     = (nxt_raw == '0) ? SEED_RST : nxt_raw;
    step    = i_en_prng & ~i_load_prng & (~o_vld_prng | i_rdy_prng);
    seed_ok = (i_seed_prng != '0);
  end

  always_ff @(posedge i_clk_prng or posedge i_rst_prng) begin
    if (i_rst_prng) begin
      state       <= SEED_RST;
      start_seed  <= SEED_RST;
      o_rnd_prng  <= '0;
      o_vld_prng  <= 1'b0;
      o_wrap_prng <= 1'b0;
      o_cnt_prng  <= '0;
      o_zerr_prng <= 1'b0;
    end else begin
      o_wrap_prng <= 1'b0;
      if (i_load_prng) begin
        state       <= seed_ok ? i_seed_prng : SEED_RST;
        start_seed  <= seed_ok ? i_seed_prng : SEED_RST;
        o_cnt_prng  <= '0;
        o_vld_prng  <= 1'b0;
        o_zerr_prng <= ~seed_ok;
      end else if (step) begin
        state      <= nxt;
        o_rnd_prng <= nxt;
        o_vld_prng <= 1'b1;
        if (nxt == start_seed) begin
          o_wrap_prng <= 1'b1;
          o_cnt_prng  <= '0;
        end else begin
          o_cnt_prng  <= o_cnt_prng + ONE;
        end
      end else if (o_vld_prng && i_rdy_prng) begin
        o_vld_prng <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: default Fibonacci, 4-bit full period and Galois instances.
module tb_lfsr_prng;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en0 = 0, ld0 = 0, rdy0 = 0;
  logic [15:0] seed0 = '0;
  logic [15:0] rnd0, cnt0;
  logic        vld0, wrap0, zerr0;

  logic        en4 = 0, ld4 = 0, rdy4 = 0;
  logic [3:0]  seed4 = '0;
  logic [3:0]  rnd4, cnt4;
  logic        vld4, wrap4, zerr4;

  logic        eng = 0, ldg = 0, rdyg = 0;
  logic [15:0] seedg = '0;
  logic [15:0] rndg, cntg;
  logic        vldg, wrapg, zerrg;

  lfsr_prng dut0 (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_en_prng(en0), .i_load_prng(ld0),
    .i_seed_prng(seed0), .i_rdy_prng(rdy0), .o_rnd_prng(rnd0), .o_vld_prng(vld0),
    .o_wrap_prng(wrap0), .o_cnt_prng(cnt0), .o_zerr_prng(zerr0)
  );

  lfsr_prng #(.DW(4), .POLY(32'hC), .MODE(0), .SEED_DEF(32'd1)) dut4 (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_en_prng(en4), .i_load_prng(ld4),
    .i_seed_prng(seed4), .i_rdy_prng(rdy4), .o_rnd_prng(rnd4), .o_vld_prng(vld4),
    .o_wrap_prng(wrap4), .o_cnt_prng(cnt4), .o_zerr_prng(zerr4)
  );

  lfsr_prng #(.MODE(1), .POLY(32'hB400)) dutg (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_en_prng(eng), .i_load_prng(ldg),
    .i_seed_prng(seedg), .i_rdy_prng(rdyg), .o_rnd_prng(rndg), .o_vld_prng(vldg),
    .o_wrap_prng(wrapg), .o_cnt_prng(cntg), .o_zerr_prng(zerrg)
  );

  typedef struct {
    logic        ld;
    logic [15:0] seed;
    logic        en;
    logic        rdy;
    logic [15:0] rnd;
    logic        vld;
    logic        wrap;
    logic [15:0] cnt;
    logic        zerr;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb0[$];
  logic [63:0] sb_small[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(logic ld, logic [15:0] sd, logic en, logic rdy,
                              logic [15:0] rnd, logic vld, logic wrap,
                              logic [15:0] cnt, logic zerr);
    vec_t v;
    v.ld = ld; v.seed = sd; v.en = en; v.rdy = rdy;
    v.rnd = rnd; v.vld = vld; v.wrap = wrap; v.cnt = cnt; v.zerr = zerr;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // got/want packing: {rnd, vld, wrap, cnt, zerr}
  task automatic run0(vec_t v, string nm);
    vec_t e;
    @(negedge clk);
    ld0 = v.ld; seed0 = v.seed; en0 = v.en; rdy0 = v.rdy;
    sb0.push_back(v);
    @(posedge clk);
    #1;
    e = sb0.pop_front();
    chk(nm, {29'd0, rnd0, vld0, wrap0, cnt0, zerr0},
            {29'd0, e.rnd, e.vld, e.wrap, e.cnt, e.zerr});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq4 [15];
    logic [3:0] w4;

    // Default instance: POLY=D008 Fibonacci from seed 1
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0002, 1, 0, 16'd1, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0004, 1, 0, 16'd2, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0008, 1, 0, 16'd3, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0011, 1, 0, 16'd4, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 16'h0000, 1, 0, 16'h0011, 1, 0, 16'd4, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0022, 1, 0, 16'd5, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0022, 0, 0, 16'd5, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0022, 0, 0, 16'd5, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 1, 16'h0022, 0, 0, 16'd0, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0002, 1, 0, 16'd1, 1));
    tbl.push_back(mk(1, 16'h00A5, 0, 1, 16'h0002, 0, 0, 16'd0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h014A, 1, 0, 16'd1, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0295, 1, 0, 16'd2, 0));
    tbl.push_back(mk(1, 16'h8000, 1, 1, 16'h0295, 0, 0, 16'd0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 16'h0001, 1, 0, 16'd1, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 16'h0001, 1, 0, 16'd1, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0002, 1, 0, 16'd2, 0));

    seq4 = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_dut0", {29'd0, rnd0, vld0, wrap0, cnt0, zerr0}, 64'd0);
    chk("reset_dut4", {53'd0, rnd4, vld4, wrap4, cnt4, zerr4}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("no_step_after_reset", {29'd0, rnd0, vld0, wrap0, cnt0, zerr0}, 64'd0);

    foreach (tbl[i]) run0(tbl[i], $sformatf("vec%0d", i));
    @(negedge clk);
    en0 = 0; ld0 = 0; rdy0 = 0;

    // 4-bit maximal sequence: wrap on step 15, one-cycle pulse
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en4 = 1; rdy4 = 1;
      w4 = seq4[i % 15];
      if (i == 14) sb_small.push_back({53'd0, w4, 1'b1, 1'b1, 4'd0, 1'b0});
      else         sb_small.push_back({53'd0, w4, 1'b1, 1'b0, 4'(i % 15 + 1), 1'b0});
      @(posedge clk); #1;
      chk($sformatf("dw4_step%0d", i + 1), {53'd0, rnd4, vld4, wrap4, cnt4, zerr4},
          sb_small.pop_front());
    end
    @(negedge clk);
    en4 = 0; rdy4 = 0;

    // Galois instance
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      eng = 1; rdyg = 1;
      sb_small.push_back({29'd0, (i == 0) ? 16'hB400 : 16'h5A00, 1'b1, 1'b0,
                          16'(i + 1), 1'b0});
      @(posedge clk); #1;
      chk($sformatf("galois_step%0d", i + 1), {29'd0, rndg, vldg, wrapg, cntg, zerrg},
          sb_small.pop_front());
    end
    @(negedge clk);
    eng = 0;

    // Asynchronous reset mid-cycle while a word is held under backpressure
    run0(mk(1, 16'h0000, 0, 0, 16'h0002, 0, 0, 16'd0, 1), "pre_rst_load0");
    run0(mk(0, 16'h0000, 1, 0, 16'h0002, 1, 0, 16'd1, 1), "pre_rst_step");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {29'd0, rnd0, vld0, wrap0, cnt0, zerr0}, 64'd0);
    @(negedge clk);
    en0 = 0; rdy0 = 1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {29'd0, rnd0, vld0, wrap0, cnt0, zerr0}, 64'd0);
    run0(mk(0, 16'h0000, 1, 1, 16'h0002, 1, 0, 16'd1, 0), "first_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
